// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types for the write-back stage
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } mem_size_e;

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - M-stage inputs and W-stage outputs of the write-back stage
interface writeback_stage_if
    import core_pkg::*;
#(
    parameter int WIDTH      = XLEN,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
);
    logic                  stall_w;
    logic                  flush_w;
    logic                  valid_m;
    logic                  reg_write_m;
    logic [1:0]            result_src_m;
    logic [1:0]            mem_size_m;
    logic                  mem_unsigned_m;
    logic [WIDTH-1:0]      alu_result_m;
    logic [WIDTH-1:0]      read_data_m;
    logic [WIDTH-1:0]      imm_ext_m;
    logic [WIDTH-1:0]      pc_plus4_m;
    logic [REG_ADDR_W-1:0] rd_m;

    logic                  valid_w;
    logic                  reg_write_w;
    logic [REG_ADDR_W-1:0] rd_w;
    logic [WIDTH-1:0]      result_w;
    logic [CNT_WIDTH-1:0]  retired_count;

    modport master (
        output stall_w, flush_w, valid_m, reg_write_m, result_src_m, mem_size_m,
               mem_unsigned_m, alu_result_m, read_data_m, imm_ext_m, pc_plus4_m, rd_m,
        input  valid_w, reg_write_w, rd_w, result_w, retired_count
    );

    modport slave (
        input  stall_w, flush_w, valid_m, reg_write_m, result_src_m, mem_size_m,
               mem_unsigned_m, alu_result_m, read_data_m, imm_ext_m, pc_plus4_m, rd_m,
        output valid_w, reg_write_w, rd_w, result_w, retired_count
    );

endinterface

// File: rtl/writeback_stage_load_extend.sv
// rtl/writeback_stage_load_extend.sv - load lane select with sign/zero extension
module load_extend
    import core_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       offset,
    input  mem_size_e        size,
    input  logic             is_unsigned,
    output logic [WIDTH-1:0] value
);

    logic [31:0] low_word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lanes always come from the low 32 bits; size-casting a signed lane sign-extends it.
    always_comb begin
        low_word  = data[31:0];
        byte_lane = low_word[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? low_word[31:16] : low_word[15:0];
        value     = '0;
        case (size)
            SZ_B: value = is_unsigned ? WIDTH'(byte_lane) : WIDTH'($signed(byte_lane));
            SZ_H: value = is_unsigned ? WIDTH'(half_lane) : WIDTH'($signed(half_lane));
            SZ_W, SZ_RSV:
                  value = is_unsigned ? WIDTH'(low_word)  : WIDTH'($signed(low_word));
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - M/W pipeline register with write-back result select
module writeback_stage
    import core_pkg::*;
#(
    parameter int WIDTH      = XLEN,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    writeback_stage_if.slave    wb
);

    logic                  valid_q;
    logic                  reg_write_q;
    result_src_e           src_q;
    mem_size_e             size_q;
    logic                  unsigned_q;
    logic [WIDTH-1:0]      alu_q;
    logic [WIDTH-1:0]      rdata_q;
    logic [WIDTH-1:0]      imm_q;
    logic [WIDTH-1:0]      pc4_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      result;

    // Pipeline register: flush inserts an all-zero bubble and beats stall; stall holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            src_q       <= RES_ALU;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            alu_q       <= '0;
            rdata_q     <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            rd_q        <= '0;
        end else if (wb.flush_w) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            src_q       <= RES_ALU;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            alu_q       <= '0;
            rdata_q     <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            rd_q        <= '0;
        end else if (!wb.stall_w) begin
            valid_q     <= wb.valid_m;
            reg_write_q <= wb.reg_write_m;
            src_q       <= result_src_e'(wb.result_src_m);
            size_q      <= mem_size_e'(wb.mem_size_m);
            unsigned_q  <= wb.mem_unsigned_m;
            alu_q       <= wb.alu_result_m;
            rdata_q     <= wb.read_data_m;
            imm_q       <= wb.imm_ext_m;
            pc4_q       <= wb.pc_plus4_m;
            rd_q        <= wb.rd_m;
        end
    end

    // Retired counter: one count per real instruction actually entering W; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (wb.valid_m && !wb.flush_w && !wb.stall_w) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    load_extend #(
        .WIDTH       (WIDTH)
    ) u_load_extend (
        .data        (rdata_q),
        .offset      (alu_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .value       (load_val)
    );

    // Result select from registered fields only, so no M input reaches W outputs combinationally.
    always_comb begin
        result = alu_q;
        case (src_q)
            RES_ALU: result = alu_q;
            RES_MEM: result = load_val;
            RES_PC4: result = pc4_q;
            RES_IMM: result = imm_q;
        endcase
    end

    assign wb.valid_w       = valid_q;
    assign wb.reg_write_w   = reg_write_q & valid_q & (rd_q != '0);
    assign wb.rd_w          = rd_q;
    assign wb.result_w      = result;
    assign wb.retired_count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;
    import core_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        stall = 0, flush = 0, valid = 0, rw = 0, uns = 0;
    logic [1:0]  src = 0, size = 0;
    logic [31:0] alu = 0, rdata = 0, imm = 0, pc4 = 0;
    logic [4:0]  rd = 0;

    writeback_stage_if #(.WIDTH(32), .REG_ADDR_W(5), .CNT_WIDTH(32)) w32 ();
    writeback_stage_if #(.WIDTH(32), .REG_ADDR_W(5), .CNT_WIDTH(4))  w4 ();

    assign w32.stall_w = stall;        assign w4.stall_w = stall;
    assign w32.flush_w = flush;        assign w4.flush_w = flush;
    assign w32.valid_m = valid;        assign w4.valid_m = valid;
    assign w32.reg_write_m = rw;       assign w4.reg_write_m = rw;
    assign w32.result_src_m = src;     assign w4.result_src_m = src;
    assign w32.mem_size_m = size;      assign w4.mem_size_m = size;
    assign w32.mem_unsigned_m = uns;   assign w4.mem_unsigned_m = uns;
    assign w32.alu_result_m = alu;     assign w4.alu_result_m = alu;
    assign w32.read_data_m = rdata;    assign w4.read_data_m = rdata;
    assign w32.imm_ext_m = imm;        assign w4.imm_ext_m = imm;
    assign w32.pc_plus4_m = pc4;       assign w4.pc_plus4_m = pc4;
    assign w32.rd_m = rd;              assign w4.rd_m = rd;

    writeback_stage #(.WIDTH(32), .REG_ADDR_W(5), .CNT_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .wb(w32.slave));
    writeback_stage #(.WIDTH(32), .REG_ADDR_W(5), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .wb(w4.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference result from plain arithmetic on the instruction fields.
    function automatic logic [31:0] exp_result(input logic [1:0] s, input logic [1:0] sz,
                                               input logic u, input logic [31:0] a,
                                               input logic [31:0] d, input logic [31:0] i,
                                               input logic [31:0] p);
        int unsigned off, v;
        if (s == 2'd0) return a;
        if (s == 2'd2) return p;
        if (s == 2'd3) return i;
        off = a % 4;
        if (sz == 2'd0) begin
            v = (d >> (8 * off)) & 255;
            if (!u && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * (off / 2))) & 65535;
            if (!u && v >= 32768) v = v - 65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // Model of what W must show: what entered, what x0 suppression leaves, how many retired.
    logic        m_valid = 0, m_rw = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_res = 0;
    logic [31:0] m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_rw <= 0; m_rd <= 0; m_res <= 0; m_cnt <= 0;
        end else if (flush) begin
            m_valid <= 0; m_rw <= 0; m_rd <= 0; m_res <= 0;
        end else if (!stall) begin
            m_valid <= valid;
            m_rw    <= rw && valid && (rd != 0);
            m_rd    <= rd;
            m_res   <= exp_result(src, size, uns, alu, rdata, imm, pc4);
            if (valid) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("cmp_valid_w", 64'(w32.valid_w), 64'(m_valid));
        chk("cmp_reg_write_w", 64'(w32.reg_write_w), 64'(m_rw));
        chk("cmp_rd_w", 64'(w32.rd_w), 64'(m_rd));
        chk("cmp_result_w", 64'(w32.result_w), 64'(m_res));
        chk("cmp_count32", 64'(w32.retired_count), 64'(m_cnt));
        chk("cmp_count4", 64'(w4.retired_count), 64'(m_cnt[3:0]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic w, input logic [1:0] s, input logic [1:0] sz,
                      input logic u, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] i, input logic [31:0] p, input logic [4:0] r);
        valid = v; rw = w; src = s; size = sz; uns = u;
        alu = a; rdata = d; imm = i; pc4 = p; rd = r;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(w32.valid_w), 0);
        chk({tag, "_rw"}, 64'(w32.reg_write_w), 0);
        chk({tag, "_rd"}, 64'(w32.rd_w), 0);
        chk({tag, "_res"}, 64'(w32.result_w), 0);
        chk({tag, "_cnt32"}, 64'(w32.retired_count), 0);
        chk({tag, "_cnt4"}, 64'(w4.retired_count), 0);
    endtask

    initial begin
        repeat (2) tick();
        chk_zero("reset");
        rst_n = 1;

        op(1, 1, 2'd0, 2'd2, 0, 32'h0000_1234, 0, 0, 0, 5'd5);
        tick();
        chk("alu_result", 64'(w32.result_w), 64'h1234);
        chk("alu_rd", 64'(w32.rd_w), 5);
        chk("alu_rw", 64'(w32.reg_write_w), 1);
        chk("alu_cnt", 64'(w32.retired_count), 1);

        op(1, 1, 2'd1, 2'd0, 0, 32'd3, 32'h80FF_7F01, 0, 0, 5'd7);
        tick();
        chk("lb_off3", 64'(w32.result_w), 64'hFFFF_FF80);
        uns = 1;
        tick();
        chk("lbu_off3", 64'(w32.result_w), 64'h0000_0080);
        op(1, 1, 2'd1, 2'd1, 0, 32'd2, 32'h80FF_7F01, 0, 0, 5'd7);
        tick();
        chk("lh_off2", 64'(w32.result_w), 64'hFFFF_80FF);

        op(1, 1, 2'd2, 2'd2, 0, 0, 0, 0, 32'h104, 5'd0);
        tick();
        chk("x0_rw", 64'(w32.reg_write_w), 0);
        chk("x0_res", 64'(w32.result_w), 64'h104);
        chk("x0_valid", 64'(w32.valid_w), 1);

        op(1, 1, 2'd0, 2'd2, 0, 32'h0000_A5A5, 0, 0, 0, 5'd9);
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            op(1, 1, 2'd3, 2'd0, 0, $urandom, $urandom, $urandom, $urandom, 5'(k + 1));
            tick();
            chk("stall_res", 64'(w32.result_w), 64'hA5A5);
            chk("stall_rd", 64'(w32.rd_w), 9);
            chk("stall_cnt", 64'(w32.retired_count), 6);
        end
        stall = 0;
        tick();
        chk("unstall_cnt", 64'(w32.retired_count), 7);

        flush = 1; stall = 1; valid = 1;
        tick();
        chk("flush_valid", 64'(w32.valid_w), 0);
        chk("flush_rw", 64'(w32.reg_write_w), 0);
        chk("flush_res", 64'(w32.result_w), 0);
        chk("flush_cnt", 64'(w32.retired_count), 7);
        flush = 0; stall = 0;

        rst_n = 0;
        tick();
        rst_n = 1;
        for (int k = 0; k < 17; k++) begin
            op(1, 1, 2'd0, 2'd2, 0, 32'(k), 0, 0, 0, 5'd3);
            tick();
        end
        chk("wrap_cnt4", 64'(w4.retired_count), 1);
        chk("wrap_cnt32", 64'(w32.retired_count), 17);

        stall = 1;
        repeat (2) tick();
        #2;
        rst_n = 0;
        #1;
        chk_zero("async_rst");
        tick();
        rst_n = 1;
        stall = 0;

        for (int n = 0; n < 600; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
               $urandom, $urandom, $urandom, $urandom,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
            if (n == 300) rst_n = 0;
            if (n == 302) rst_n = 1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised M/W pipeline register plus write-back result select for the pipelined RV32I core.
- Successor to the fixed 32-bit write-back stage. Adds:
  - valid tracking, stall hold and flush bubble
  - load byte/half extraction with sign/zero extension
  - an LUI immediate result source
  - x0 write suppression
  - a retired-instruction counter
- Sits between the memory stage and the register file; its outputs also feed the hazard/forwarding unit.

Parameters:
- WIDTH, 32, datapath width in bits (multiple of 16, ≥32)
- REG_ADDR_W, 5, register index width
- CNT_WIDTH, 32, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_w  in  1  hold W-stage contents this cycle
- flush_w  in  1  load a bubble into W this cycle
- valid_m  in  1  M-stage holds a real instruction
- reg_write_m  in  1  instruction writes rd
- result_src_m  in  2  00 ALU, 01 load data, 10 PC+4, 11 immediate
- mem_size_m  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_unsigned_m  in  1  1 = zero-extend load, 0 = sign-extend
- alu_result_m  in  WIDTH  ALU result; bits [1:0] give byte offset for loads
- read_data_m  in  WIDTH  aligned word read from data memory
- imm_ext_m  in  WIDTH  extended immediate (LUI)
- pc_plus4_m  in  WIDTH  return address
- rd_m  in  REG_ADDR_W  destination register
- valid_w  out  1  W-stage holds a real instruction
- reg_write_w  out  1  register-file write enable
- rd_w  out  REG_ADDR_W  register-file write address
- result_w  out  WIDTH  register-file write data
- retired_count  out  CNT_WIDTH  number of instructions accepted into W

Behaviour:
- Reset (rst_n low, asynchronous): all internal registers cleared. Outputs become valid_w=0, reg_write_w=0, rd_w=0, result_w=0, retired_count=0. Reset mid-stall or mid-flush discards state; the first edge after deassertion behaves normally.
- Register update at each posedge, in priority order:
  1. flush_w=1: valid and reg_write registers cleared; all data/field registers cleared to 0. Flush wins over stall.
  2. else stall_w=1: every register holds.
  3. else: all *_m inputs captured.
- Latency: one cycle from *_m inputs to outputs. Everything after the registers is combinational from registered fields only; no *_m input reaches an output combinationally.
- reg_write_w = reg_write_q & valid_q & (rd_q != 0). Writes to x0 are never issued.
- rd_w is the registered rd, unmasked.
- result_w select on registered result_src:
  - 00: ALU result
  - 01: load value
  - 10: PC+4
  - 11: immediate
- Load value, using registered offset = alu_result[1:0]:
  - byte: lane = read_data[8*offset +: 8]
  - half: lane = read_data[16*offset[1] +: 16]; offset[0] ignored (misaligned half not trapped here)
  - word or reserved (11): full read_data
  - Lane is sign-extended (unsigned=0) or zero-extended (unsigned=1) to WIDTH.
  - For WIDTH>32, byte/half lanes index the low 32 bits only; word is zero/sign-extended from 32 bits per unsigned.
- retired_count:
  - Increments by 1 on an edge where valid_m=1, flush_w=0 and stall_w=0, i.e. once per instruction entering W.
  - Stalled cycles never double-count.
  - Wraps from all-ones to 0 silently.
- Simultaneous flush and stall: flush applied, counter not incremented.
- No handshake back-pressure generated; stall/flush come from the hazard unit.

Decomposition:
- Shared package core_pkg holds:
  - result_src_e (RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_IMM=2'b11)
  - mem_size_e (SZ_B, SZ_H, SZ_W, SZ_RSV)
  - default XLEN=32 constant
- One sub-module: load_extend (combinational lane select plus extension; inputs data, offset, size, unsigned).
- The result mux stays inline.

Test Plan:
- Reset then single ALU op (valid_m=1, reg_write_m=1, src=00, alu=0x0000_1234, rd=5) → next cycle result_w=0x0000_1234, rd_w=5, reg_write_w=1, retired_count=1.
- Byte load, read_data=0x80FF_7F01, alu[1:0]=3, signed → result_w=0xFFFF_FF80. Same with unsigned → 0x0000_0080. Half offset 2, signed → 0xFFFF_80FF.
- rd_m=0 with reg_write_m=1, src=10, pc_plus4=0x104 → reg_write_w=0, result_w=0x104, valid_w=1.
- Capture op A, then stall_w=1 for 3 cycles while M changes → outputs hold A; retired_count rises by 1 total, not 4.
- flush_w=1 together with stall_w=1 and valid_m=1 → next cycle valid_w=0, reg_write_w=0, result_w=0, counter unchanged.
- Preload counter near wrap: run with CNT_WIDTH=4 for 17 accepted ops → retired_count=1. Assert rst_n low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
